// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one multi-cycle unified memory port between the IF stage
//   (instruction reads) and the MEM stage (data loads/stores). Each access is
//   sequenced IDLE -> ACCESS -> RESP -> IDLE. Data requests win arbitration,
//   except when IF has watched STARVE_LIMIT data grants go past it in a row.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   if_req/if_addr        instruction read request (held until if_ack)
//   if_ack/if_rdata       1-cycle completion pulse and fetched 32-bit word
//   d_req/d_we/d_width/
//   d_addr/d_wdata        data request (held until d_ack), store when d_we=1
//   d_ack/d_rdata         1-cycle completion pulse and 64-bit load data
//   mem_en/mem_we/
//   mem_width/mem_addr/
//   mem_wdata/mem_rdata   unified memory port
//   busy/owner            FSM not idle / current owner (1=data, 0=IF)
//   stall_if/stall_mem    pipeline stall requests
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH   = 64,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_ack,
   output logic [31:0]           if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [2:0]            d_width,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [63:0]           d_wdata,
   output logic                  d_ack,
   output logic [63:0]           d_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [2:0]            mem_width,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [63:0]           mem_wdata,
   input  logic [63:0]           mem_rdata,
   output logic                  busy,
   output logic                  owner,
   output logic                  stall_if,
   output logic                  stall_mem
);

   // A one-cycle memory needs a 1-bit counter that only ever holds zero.
   localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  w_grantIf;
   logic                  w_grantD;
   logic [CNT_W-1:0]      r_cnt;
   logic [STARVE_W-1:0]   r_starve;
   logic                  r_owner;
   logic                  r_we;
   logic                  r_ifHi;
   logic [2:0]            r_width;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [63:0]           r_wdata;
   logic [31:0]           r_ifRdata;
   logic [63:0]           r_dRdata;

   // Next-state and grant decision. IF only beats a pending data request once
   // the starvation counter has reached its limit.
   always_comb begin
      w_next    = r_state;
      w_grantIf = 1'b0;
      w_grantD  = 1'b0;
      case (r_state)
         IDLE: begin
            if (if_req && (!d_req || (r_starve == STARVE_MAX))) begin
               w_grantIf = 1'b1;
            end else if (d_req) begin
               w_grantD = 1'b1;
            end
            if (w_grantIf || w_grantD) begin
               w_next = ACCESS;
            end
         end
         ACCESS: begin
            if (r_cnt == '0) begin
               w_next = RESP;
            end
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register plus everything latched at grant or captured at the end
   // of the access. Requester inputs are only looked at in IDLE, so changes
   // during an access cannot disturb the memory port.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_starve  <= '0;
         r_owner   <= 1'b0;
         r_we      <= 1'b0;
         r_ifHi    <= 1'b0;
         r_width   <= 3'b000;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_ifRdata <= '0;
         r_dRdata  <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (w_grantIf) begin
                  r_owner <= 1'b0;
                  r_we    <= 1'b0;
                  r_width <= 3'b010;
                  r_addr  <= if_addr;
                  r_wdata <= '0;
                  r_ifHi  <= if_addr[2];
                  r_cnt   <= CNT_LOAD;
               end else if (w_grantD) begin
                  r_owner <= 1'b1;
                  r_we    <= d_we;
                  r_width <= d_width;
                  r_addr  <= d_addr;
                  r_wdata <= d_wdata;
                  r_cnt   <= CNT_LOAD;
               end
               // Starvation only counts data grants that overtook a waiting IF.
               if (!if_req || w_grantIf) begin
                  r_starve <= '0;
               end else if (w_grantD && (r_starve != STARVE_MAX)) begin
                  r_starve <= r_starve + STARVE_W'(1);
               end
            end
            ACCESS: begin
               if (r_cnt == '0) begin
                  if (!r_owner) begin
                     r_ifRdata <= r_ifHi ? mem_rdata[63:32] : mem_rdata[31:0];
                  end else if (!r_we) begin
                     r_dRdata <= mem_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // The memory port is driven straight from the latched request, so it is
   // stable for the whole ACCESS window and quiet everywhere else.
   always_comb begin
      mem_en    = (r_state == ACCESS);
      mem_we    = (r_state == ACCESS) && r_we && r_owner;
      mem_width = r_width;
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
      if_ack    = (r_state == RESP) && !r_owner;
      d_ack     = (r_state == RESP) && r_owner;
      if_rdata  = r_ifRdata;
      d_rdata   = r_dRdata;
      busy      = (r_state != IDLE);
      owner     = r_owner;
      stall_if  = if_req && !if_ack;
      stall_mem = d_req && !d_ack;
   end

endmodule
